// File: rtl/matrak_pkg.sv
// Shared definitions for the matrak core front end.
//   RESET_ADDR_DEFAULT : default first fetch address after reset
//   INST_W             : instruction word width
//   NOP_INST           : canonical no-operation encoding (addi x0,x0,0)
//   fetch_entry_t      : one instruction queue entry {pc, inst}
package matrak_pkg;

  localparam logic [31:0]       RESET_ADDR_DEFAULT = 32'h0000_0000;
  localparam int unsigned       INST_W             = 32;
  localparam logic [INST_W-1:0] NOP_INST           = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue of {pc, inst} entries.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : empty the queue (wins over push and pop)
//   i_push, i_data : write one entry (accepted when not full or popping)
//   i_pop          : remove the head entry (ignored when empty)
//   o_data         : head entry, registered storage (no fall-through)
//   o_full, o_empty, o_count : occupancy status
module fetch_fifo
  import matrak_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_flush,
  input  logic                             i_push,
  input  fetch_entry_t                     i_data,
  input  logic                             i_pop,
  output fetch_entry_t                     o_data,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [$clog2(DEPTH + 1)-1:0]     o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  // Pointers wrap at DEPTH-1 so non power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_count   = r_cnt;
  assign o_data    = r_mem[r_rp];
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer and occupancy bookkeeping; flush overrides push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wp <= ptr_next(r_wp);
      if (w_do_pop)  r_rp <= ptr_next(r_rp);
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Entry storage; cleared on reset so the head reads as zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wp] <= i_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches to instruction
// memory, queues returned words with their addresses, and hands them to
// decode with a valid/ready handshake. A redirect flushes the queue and
// discards responses still in flight.
// Ports:
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   imem_req_o/imem_addr_o         : fetch request and word address
//   imem_gnt_i                     : request accepted this cycle
//   imem_rvalid_i/imem_rdata_i     : in-order response
//   redirect_i/redirect_pc_i       : flush and restart at new PC
//   inst_valid_o/inst_ready_i      : decode handshake
//   inst_o/pc_o                    : instruction and its address
module fetch_unit
  import matrak_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter int unsigned DEPTH      = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [31:0]       imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [31:0]       pc_o
);

  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam logic [31:0] START_PC = RESET_ADDR & 32'hFFFF_FFFC;

  logic          r_run;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;
  logic [31:0]   r_tag [DEPTH];
  logic [PW-1:0] r_tag_wp;
  logic [PW-1:0] r_tag_rp;

  logic          w_grant;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_inflight_nxt;
  logic [CW:0]   w_total;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_cnt;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign inst_valid_o = ~w_fifo_empty;
  assign inst_o       = w_head.inst;
  assign pc_o         = w_head.pc;
  assign imem_addr_o  = r_pc;

  assign w_pop   = inst_valid_o & inst_ready_i;
  assign w_grant = imem_req_o & imem_gnt_i;
  assign w_drop  = (r_discard != '0);
  assign w_push  = imem_rvalid_i & ~redirect_i & ~w_drop;

  // Queue slots freed by this cycle's pop count as available, which is what
  // lets a zero-wait memory sustain one instruction per cycle at DEPTH=2.
  assign w_total = {1'b0, w_fifo_cnt} + {1'b0, r_inflight} - {{CW{1'b0}}, w_pop};
  assign imem_req_o = r_run & ~(w_fifo_full & ~w_pop) & (w_total < (CW+1)'(DEPTH));

  assign w_inflight_nxt = r_inflight + CW'(w_grant) - CW'(imem_rvalid_i);
  // Responses return in order, so the oldest tag is the response address.
  assign w_push_entry   = {r_tag[r_tag_rp], imem_rdata_i};

  // Fetch PC, in-flight/discard counters and tag pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run      <= 1'b0;
      r_pc       <= START_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_tag_wp   <= '0;
      r_tag_rp   <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_inflight_nxt;
      // Tags track every request, including ones that will be discarded,
      // so they stay aligned with the response stream across redirects.
      if (w_grant)       r_tag_wp <= ptr_next(r_tag_wp);
      if (imem_rvalid_i) r_tag_rp <= ptr_next(r_tag_rp);
      if (redirect_i) begin
        r_pc      <= redirect_pc_i & 32'hFFFF_FFFC;
        r_discard <= w_inflight_nxt;
      end else begin
        if (w_grant)                r_pc      <= r_pc + 32'd4;
        if (imem_rvalid_i && w_drop) r_discard <= r_discard - CW'(1);
      end
    end
  end

  // Address tag storage for outstanding requests.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) r_tag[i] <= 32'h0;
    end else if (w_grant) begin
      r_tag[r_tag_wp] <= r_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// stream, all checked against a queue-based model of the fetch contract.
module tb_fetch_unit;
  import matrak_pkg::*;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  always #5 clk_i = ~clk_i;

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] mem_q [$];   // addresses granted, awaiting response
  logic [63:0] exp_q [$];   // {pc, inst} expected in the instruction queue
  int          discard;
  logic [31:0] exp_fetch;   // next address the unit must request
  logic [31:0] exp_stream;  // next pc decode must receive
  int          gnt_pct, rv_pct, rdy_pct;
  logic        redir_now = 1'b0;
  logic [31:0] redir_pc  = 32'h0;
  logic        prev_stall, prev_redir;
  logic [31:0] prev_addr;
  logic        o_req, o_valid;
  logic [31:0] o_addr, o_pc, o_inst;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[4:2] == 3'd3) return NOP_INST;
    return a ^ 32'h5A3C_96E1;
  endfunction

  task automatic model_clear();
    mem_q.delete();
    exp_q.delete();
    discard    = 0;
    exp_fetch  = 32'h0;
    exp_stream = 32'h0;
    prev_stall = 1'b0;
    prev_redir = 1'b0;
  endtask

  // One clock: drive at the falling edge, observe, check, advance the model.
  task automatic cycle();
    logic grant, raw_pop, pop, rv;
    logic [31:0] ra;
    @(negedge clk_i);
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    rv            = (mem_q.size() > 0) && ($urandom_range(99) < rv_pct);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(mem_q[0]) : $urandom;
    inst_ready_i  = ($urandom_range(99) < rdy_pct);
    redirect_i    = redir_now;
    redirect_pc_i = redir_now ? redir_pc : $urandom;
    #1;
    o_req = imem_req_o; o_addr = imem_addr_o; o_valid = inst_valid_o;
    o_pc = pc_o; o_inst = inst_o;
    check("addr_align", 64'(o_addr[1:0]), 64'd0);
    if (prev_stall) begin
      check("req_hold", 64'(o_req), 64'd1);
      check("addr_hold", 64'(o_addr), 64'(prev_addr));
    end
    if (prev_redir) check("valid_after_redirect", 64'(o_valid), 64'd0);
    check("valid", 64'(o_valid), 64'(exp_q.size() != 0));
    if (o_valid && exp_q.size() != 0) check("head", {o_pc, o_inst}, exp_q[0]);
    raw_pop = o_valid & inst_ready_i;
    if (o_req)
      check("req_bound", 64'((exp_q.size() + mem_q.size() - int'(raw_pop)) < DEPTH), 64'd1);
    grant = o_req & imem_gnt_i;
    pop   = raw_pop & ~redirect_i;
    if (pop) begin
      check("pop_pc", 64'(o_pc), 64'(exp_stream));
      exp_stream += 32'd4;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (rv) begin
      ra = mem_q.pop_front();
      if (!redirect_i) begin
        if (discard > 0) discard--;
        else exp_q.push_back({ra, mem_word(ra)});
      end
    end
    if (grant) begin
      check("grant_addr", 64'(o_addr), 64'(exp_fetch));
      mem_q.push_back(exp_fetch);
      exp_fetch += 32'd4;
    end
    if (redirect_i) begin
      exp_q.delete();
      discard    = mem_q.size();
      exp_fetch  = redir_pc & 32'hFFFF_FFFC;
      exp_stream = exp_fetch;
    end
    prev_stall = o_req & ~imem_gnt_i & ~redirect_i;
    prev_addr  = o_addr;
    prev_redir = redirect_i;
    redir_now  = 1'b0;
  endtask

  // Async reset between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_req", 64'(imem_req_o), 64'd0);
    check("rst_valid", 64'(inst_valid_o), 64'd0);
    check("rst_inst", 64'(inst_o), 64'd0);
    check("rst_pc", 64'(pc_o), 64'd0);
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0; inst_ready_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int cnt;
    logic found;
    logic [31:0] tgt;

    // Zero-wait memory, decode always ready: 0,4,8.. then 1 inst/cycle.
    do_reset();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (c == 0) begin
        check("c0_req", 64'(o_req), 64'd1);
        check("c0_addr", 64'(o_addr), 64'h0);
      end
      if (c == 1) check("c1_valid", 64'(o_valid), 64'd0);
      if (c == 2) check("c2_pc", 64'(o_pc), 64'h0);
      if (c >= 2) check("throughput_valid", 64'(o_valid), 64'd1);
    end

    // Decode stalls 10 cycles: exactly DEPTH queued, request dropped.
    rdy_pct = 0;
    repeat (10) cycle();
    check("bp_req_low", 64'(o_req), 64'd0);
    check("bp_valid", 64'(o_valid), 64'd1);
    gnt_pct = 0; rdy_pct = 100; cnt = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (o_valid) cnt++;
    end
    check("bp_queued", 64'(cnt), 64'(DEPTH));
    gnt_pct = 100;
    repeat (8) cycle();

    // Grant withheld 3 cycles at 0x8.
    do_reset();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    repeat (2) cycle();
    gnt_pct = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("gstall_req", 64'(o_req), 64'd1);
      check("gstall_addr", 64'(o_addr), 64'h8);
    end
    gnt_pct = 100;
    cycle();
    check("gstall_grant_addr", 64'(o_addr), 64'h8);
    cycle();
    check("gstall_next_addr", 64'(o_addr), 64'hC);
    repeat (4) cycle();

    // Redirect to 0x103 with two requests in flight.
    do_reset();
    gnt_pct = 100; rv_pct = 0; rdy_pct = 100;
    repeat (3) cycle();
    check("r2_req_full", 64'(o_req), 64'd0);
    redir_now = 1'b1; redir_pc = 32'h0000_0103;
    cycle();
    cycle();
    check("r2_addr", 64'(o_addr), 64'h100);
    rv_pct = 100;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("r2_dropped", 64'(o_valid), 64'd0);
    end
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      cycle();
      if (o_valid) begin
        found = 1'b1;
        check("r2_first_pc", 64'(o_pc), 64'h100);
      end
    end
    check("r2_first_found", 64'(found), 64'd1);

    // Redirect coincident with rvalid, grant and pop.
    repeat (6) cycle();
    tgt = $urandom | 32'h0000_0002;
    redir_now = 1'b1; redir_pc = tgt;
    cycle();
    check("rc_coincident", 64'({o_req, o_valid, imem_rvalid_i}), 64'h7);
    cycle();
    check("rc_empty", 64'(o_valid), 64'd0);
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      cycle();
      if (o_valid) begin
        found = 1'b1;
        check("rc_first_pc", 64'(o_pc), 64'(tgt & 32'hFFFF_FFFC));
      end
    end
    check("rc_first_found", 64'(found), 64'd1);

    // Reset pulsed mid-stream; fetch restarts at the reset address.
    repeat (5) cycle();
    do_reset();
    cycle();
    check("rr_req", 64'(o_req), 64'd1);
    check("rr_addr", 64'(o_addr), 64'h0);
    repeat (6) cycle();

    // Randomized stream with random redirects, including one near wrap.
    do_reset();
    for (int i = 0; i < 900; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = $urandom_range(40, 100);
        rv_pct  = $urandom_range(40, 100);
        rdy_pct = $urandom_range(30, 100);
      end
      if (i == 400) begin
        redir_now = 1'b1; redir_pc = 32'hFFFF_FFF5;
      end else if ($urandom_range(99) < 4) begin
        redir_now = 1'b1;
        redir_pc  = $urandom;
      end
      cycle();
    end
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    repeat (10) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h0000_0000, first instruction address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction queue entries; legal values 2..8, and sets the maximum of queued plus in-flight fetches.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_req_o, output, 1, fetch request to instruction memory.
REQ-006 SHALL have port imem_addr_o, output, 32, fetch address; bits [1:0] always 2'b00.
REQ-007 SHALL have port imem_gnt_i, input, 1, memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid_i, input, 1, response data valid; responses arrive in request order.
REQ-009 SHALL have port imem_rdata_i, input, 32, fetched instruction word.
REQ-010 SHALL have port redirect_i, input, 1, flush and restart fetch at redirect_pc_i.
REQ-011 SHALL have port redirect_pc_i, input, 32, new fetch address; bits [1:0] ignored.
REQ-012 SHALL have port inst_valid_o, output, 1, inst_o and pc_o hold a valid instruction.
REQ-013 SHALL have port inst_ready_i, input, 1, the decode stage consumes the instruction this cycle.
REQ-014 SHALL have port inst_o, output, 32, instruction for the fetch/decode pipeline register.
REQ-015 SHALL have port pc_o, output, 32, address of inst_o.

Function
REQ-016 SHALL assert imem_req_o only when (queue occupancy + in-flight count) < DEPTH.
REQ-017 SHALL hold imem_req_o and imem_addr_o stable while imem_req_o=1 and imem_gnt_i=0, except on redirect.
REQ-018 SHALL advance the fetch PC by 4 on each cycle where imem_req_o=1 and imem_gnt_i=1; wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 SHALL increment the in-flight count on grant, decrement it on rvalid, and leave it unchanged when both occur in the same cycle.
REQ-020 SHALL write {fetch address, imem_rdata_i} into the queue on rvalid when the discard count is 0; the address comes from an in-order address tag.
REQ-021 SHALL expose the queue head on inst_o/pc_o with inst_valid_o = queue not empty; the head is popped on inst_valid_o and inst_ready_i.
REQ-022 SHALL register queue writes, so an instruction is visible on inst_valid_o one cycle after its rvalid (no fall-through).
REQ-023 SHALL sustain one instruction per cycle with zero-wait memory (gnt always 1, rvalid one cycle after grant) and inst_ready_i=1.
REQ-024 SHALL support a simultaneous queue push and pop when full; occupancy is unchanged.
REQ-025 SHALL, on redirect_i=1, do all of the following in that cycle: empty the queue; drop any rvalid in that cycle; set the discard count to in-flight responses including a grant in that cycle; load fetch PC = {redirect_pc_i[31:2],2'b00}.
REQ-026 SHALL drop responses while the discard count > 0, decrementing it per rvalid; dropped responses never reach the queue.
REQ-027 SHALL give redirect priority over pop, push and PC increment in the same cycle.
REQ-028 SHALL drive imem_addr_o = redirect target from the cycle after redirect, even if an ungranted request was pending.
REQ-029 SHALL force inst_valid_o=0 in the cycle after a redirect.

Reset
REQ-030 SHALL, on rst_ni=0, asynchronously set: fetch PC=RESET_ADDR, queue empty, in-flight=0, discard=0, imem_req_o=0, inst_valid_o=0, inst_o=32'h0, pc_o=32'h0.
REQ-031 SHALL assert imem_req_o with imem_addr_o=RESET_ADDR in the first clock after rst_ni deasserts.
REQ-032 SHALL treat reset mid-operation as discarding all queued and in-flight state; the memory is reset together with this block.

Structure
REQ-033 SHALL take RESET_ADDR default, instruction width (32) and the NOP encoding 32'h0000_0013 from shared package matrak_pkg.
REQ-034 SHALL contain one sub-module fetch_fifo, a synchronous DEPTH-entry FIFO of {pc, inst} with push, pop, full, empty and flush.

Verification
REQ-035 SHALL cover: reset release, zero-wait memory, ready=1 -> addresses 0,4,8… issued; first inst_valid_o at cycle 2 with pc_o=0; then one instruction per cycle.
REQ-036 SHALL cover: inst_ready_i=0 for 10 cycles -> exactly DEPTH (2) instructions queued; imem_req_o low; no data lost after ready returns.
REQ-037 SHALL cover: gnt stalled 3 cycles at addr 0x8 -> imem_req_o/imem_addr_o stable at 0x8; PC advances only after grant.
REQ-038 SHALL cover: redirect to 0x103 with 2 in flight -> next address 0x100; 2 responses dropped; next pc_o=0x100.
REQ-039 SHALL cover: redirect coincident with rvalid, grant and pop -> queue empty; the rvalid data is dropped; the granted response is discarded.
REQ-040 SHALL cover: rst_ni pulsed low mid-stream asynchronously (between clock edges) -> all outputs at reset values immediately; fetch restarts at RESET_ADDR.
